// File: rtl/sdram_arb_pkg.sv
// sdram_arbiter shared types
// command word layout and response FSM states
package sdram_arb_pkg;

  localparam int CMD_W  = 41;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic {
    R_IDLE,
    R_CAP
  } rsp_state_t;

  // Reads carry no payload, so their data field is zeroed
  function automatic cmd_t mk_cmd(
    input logic              we,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    cmd_t c;
    c.we   = we;
    c.addr = addr;
    c.data = we ? data : '0;
    return c;
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter client-side bus
// request/accept and read-data return for all clients
interface sdram_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  import sdram_arb_pkg::*;

  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_we_i;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ-1:0]             rsp_valid_o;
  logic [DATA_W-1:0]              rsp_data_o;

  modport master (
    output req_valid_i,
    output req_we_i,
    output req_addr_i,
    output req_data_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_data_o
  );

  modport slave (
    input  req_valid_i,
    input  req_we_i,
    input  req_addr_i,
    input  req_data_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_data_o
  );

endinterface

// File: rtl/sdram_tag_fifo.sv
// sdram_tag_fifo: in-order tags of outstanding reads
// synchronous FIFO with simultaneous push/pop support
module sdram_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     i_push,
  input  logic [W-1:0]             i_tag,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wr;
  logic [AW-1:0]           r_rd;
  logic [LW-1:0]           r_lvl;
  logic                    w_push;
  logic                    w_pop;

  assign o_full  = (r_lvl == LW'(DEPTH));
  assign o_empty = (r_lvl == '0);
  assign o_head  = r_mem[r_rd];
  assign o_level = r_lvl;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage, pointers and level; push+pop leaves level unchanged
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_tag;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_lvl <= r_lvl + 1'b1;
      end else if (w_pop && !w_push) begin
        r_lvl <= r_lvl - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin client mux for async_sdram_ctrl
// serialises commands, routes read data back by tag
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_i,
  sdram_arbiter_if.slave             cli,
  output logic [CMD_W-1:0]           writer_d_o,
  output logic                       writer_enq_o,
  input  logic                       writer_full_i,
  input  logic [DATA_W-1:0]          reader_q_i,
  output logic                       reader_deq_o,
  input  logic                       reader_empty_i,
  output logic [$clog2(TAG_DEPTH):0] outstanding_o,
  output logic                       err_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]       r_ptr;
  cmd_t                r_cmd;
  logic                r_enq;
  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_ready;
  logic [PW-1:0]       w_gnt;
  logic                w_found;
  logic                w_accept;
  int                  w_idx;

  logic                w_tag_full;
  logic                w_tag_empty;
  logic [PW-1:0]       w_head;
  logic                w_push;

  rsp_state_t          r_state;
  rsp_state_t          w_next;
  logic                r_deq;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_err;
  logic                w_deq_d;
  logic                w_pop;
  logic                w_load;
  logic                w_err_set;

  // Eligibility and upward search from the round-robin pointer
  always_comb begin
    w_elig  = '0;
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = cli.req_valid_i[i] &&
                  (cli.req_we_i[i] || !w_tag_full);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!w_found && w_elig[PW'(w_idx)]) begin
        w_found = 1'b1;
        w_gnt   = PW'(w_idx);
      end
    end
  end

  // The gap after each enqueue lets the full flag catch up
  assign w_accept = !writer_full_i && !r_enq && w_found;
  assign w_push   = w_accept && !cli.req_we_i[w_gnt];

  // One-hot accept strobe for the granted client
  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready[w_gnt] = 1'b1;
    end
  end

  assign cli.req_ready_o = w_ready;

  // Command register, enqueue strobe and pointer advance
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_cmd <= '0;
      r_enq <= 1'b0;
      r_ptr <= '0;
    end else begin
      r_enq <= w_accept;
      if (w_accept) begin
        r_cmd <= mk_cmd(cli.req_we_i[w_gnt],
                        cli.req_addr_i[w_gnt],
                        cli.req_data_i[w_gnt]);
        if (int'(w_gnt) == NUM_REQ - 1) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_gnt + 1'b1;
        end
      end
    end
  end

  sdram_tag_fifo #(
    .W     (PW),
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .clk     (clk),
    .reset_i (reset_i),
    .i_push  (w_push),
    .i_tag   (w_gnt),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_level (outstanding_o)
  );

  // Response FSM state register
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: dequeue, then capture the word a cycle later
  always_comb begin
    w_next    = r_state;
    w_deq_d   = 1'b0;
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (!reader_empty_i) begin
          w_deq_d = 1'b1;
          w_next  = R_CAP;
        end
      end
      R_CAP: begin
        w_next = R_IDLE;
        if (!w_tag_empty) begin
          w_pop  = 1'b1;
          w_load = 1'b1;
        end else begin
          w_err_set = 1'b1;
        end
      end
      default: w_next = R_IDLE;
    endcase
  end

  // Registered response strobes, data and sticky error
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_deq       <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_deq       <= w_deq_d;
      r_rsp_valid <= '0;
      if (w_load) begin
        r_rsp_valid[w_head] <= 1'b1;
        r_rsp_data          <= reader_q_i;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign writer_d_o      = r_cmd;
  assign writer_enq_o    = r_enq;
  assign reader_deq_o    = r_deq;
  assign cli.rsp_valid_o = r_rsp_valid;
  assign cli.rsp_data_o  = r_rsp_data;
  assign err_o           = r_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios for sdram_arbiter
// hand-computed expectations per task
module tb_sdram_arbiter;

  logic        clk;
  logic        reset_i;
  logic [40:0] writer_d_o;
  logic        writer_enq_o;
  logic        writer_full_i;
  logic [15:0] reader_q_i;
  logic        reader_deq_o;
  logic        reader_empty_i;
  logic [3:0]  outstanding_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  sdram_arbiter_if #(.NUM_REQ(4)) cli ();

  sdram_arbiter #(
    .NUM_REQ   (4),
    .TAG_DEPTH (8)
  ) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .cli            (cli),
    .writer_d_o     (writer_d_o),
    .writer_enq_o   (writer_enq_o),
    .writer_full_i  (writer_full_i),
    .reader_q_i     (reader_q_i),
    .reader_deq_o   (reader_deq_o),
    .reader_empty_i (reader_empty_i),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cli.req_valid_i = '0;
    cli.req_we_i    = '0;
    cli.req_addr_i  = '0;
    cli.req_data_i  = '0;
    writer_full_i   = 1'b0;
    reader_q_i      = '0;
    reader_empty_i  = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
  endtask

  task automatic send_rsp(input logic [15:0] d);
    reader_q_i     = d;
    reader_empty_i = 1'b0;
    tick();
    reader_empty_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    checks++;
    if ({writer_enq_o, reader_deq_o, err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000",
               {writer_enq_o, reader_deq_o, err_o});
    end
    checks++;
    if (cli.rsp_valid_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rsp_valid: got %b expected 0000",
               cli.rsp_valid_o);
    end
    checks++;
    if (writer_d_o !== 41'h0 || cli.rsp_data_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h expected 0/0",
               writer_d_o, cli.rsp_data_o);
    end
    checks++;
    if (outstanding_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_outstanding: got %0d expected 0",
               outstanding_o);
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    cli.req_valid_i[1] = 1'b1;
    cli.req_we_i[1]    = 1'b1;
    cli.req_addr_i[1]  = 24'h000010;
    cli.req_data_i[1]  = 16'hBEEF;
    #1;
    checks++;
    if (cli.req_ready_o !== 4'b0010 || writer_enq_o !== 1'b0) begin
      errors++;
      $display("FAIL sw_ready: got %b/%b expected 0010/0",
               cli.req_ready_o, writer_enq_o);
    end
    tick();
    cli.req_valid_i = '0;
    checks++;
    if (writer_enq_o !== 1'b1 ||
        writer_d_o !== {1'b1, 24'h000010, 16'hBEEF}) begin
      errors++;
      $display("FAIL sw_cmd: got %b/%h expected 1/%h",
               writer_enq_o, writer_d_o,
               {1'b1, 24'h000010, 16'hBEEF});
    end
    tick();
    checks++;
    if (writer_enq_o !== 1'b0) begin
      errors++;
      $display("FAIL sw_enq_pulse: got %b expected 0",
               writer_enq_o);
    end
  endtask

  task automatic test_round_robin();
    int          e;
    logic [23:0] ea;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cli.req_valid_i[i] = 1'b1;
      cli.req_we_i[i]    = 1'b0;
      cli.req_addr_i[i]  = 24'h000100 + 24'(i);
      cli.req_data_i[i]  = 16'hFFFF;
    end
    #1;
    for (int g = 0; g < 5; g++) begin
      e  = g % 4;
      ea = 24'h000100 + 24'(e);
      checks++;
      if (cli.req_ready_o !== (4'b0001 << e) ||
          writer_enq_o !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b/%b expected %b/0",
                 g, cli.req_ready_o, writer_enq_o,
                 4'b0001 << e);
      end
      tick();
      checks++;
      if (writer_enq_o !== 1'b1 ||
          writer_d_o !== {1'b0, ea, 16'h0000}) begin
        errors++;
        $display("FAIL rr_cmd%0d: got %b/%h expected 1/%h",
                 g, writer_enq_o, writer_d_o,
                 {1'b0, ea, 16'h0000});
      end
      checks++;
      if (cli.req_ready_o !== 4'b0000) begin
        errors++;
        $display("FAIL rr_gap%0d: got %b expected 0000",
                 g, cli.req_ready_o);
      end
      tick();
    end
    cli.req_valid_i = '0;
    checks++;
    if (outstanding_o !== 4'd5) begin
      errors++;
      $display("FAIL rr_outstanding: got %0d expected 5",
               outstanding_o);
    end
  endtask

  task automatic test_read_routing();
    do_reset();
    cli.req_valid_i[2] = 1'b1;
    cli.req_addr_i[2]  = 24'h000222;
    #1;
    checks++;
    if (cli.req_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL rd_grant2: got %b expected 0100",
               cli.req_ready_o);
    end
    tick();
    cli.req_valid_i[2] = 1'b0;
    cli.req_valid_i[0] = 1'b1;
    cli.req_addr_i[0]  = 24'h000333;
    tick();
    checks++;
    if (cli.req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL rd_grant0: got %b expected 0001",
               cli.req_ready_o);
    end
    tick();
    cli.req_valid_i[0] = 1'b0;
    checks++;
    if (outstanding_o !== 4'd2) begin
      errors++;
      $display("FAIL rd_outstanding: got %0d expected 2",
               outstanding_o);
    end
    reader_q_i     = 16'h1111;
    reader_empty_i = 1'b0;
    tick();
    reader_empty_i = 1'b1;
    checks++;
    if (reader_deq_o !== 1'b1 || cli.rsp_valid_o !== 4'b0000) begin
      errors++;
      $display("FAIL rd_deq: got %b/%b expected 1/0000",
               reader_deq_o, cli.rsp_valid_o);
    end
    tick();
    checks++;
    if (cli.rsp_valid_o !== 4'b0100 ||
        cli.rsp_data_o !== 16'h1111 || reader_deq_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_rsp1: got %b/%h/%b expected 0100/1111/0",
               cli.rsp_valid_o, cli.rsp_data_o, reader_deq_o);
    end
    send_rsp(16'h2222);
    checks++;
    if (cli.rsp_valid_o !== 4'b0001 ||
        cli.rsp_data_o !== 16'h2222 || outstanding_o !== 4'd0) begin
      errors++;
      $display("FAIL rd_rsp2: got %b/%h/%0d expected 0001/2222/0",
               cli.rsp_valid_o, cli.rsp_data_o, outstanding_o);
    end
    tick();
    checks++;
    if (cli.rsp_valid_o !== 4'b0000 ||
        cli.rsp_data_o !== 16'h2222 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_hold: got %b/%h/%b expected 0000/2222/0",
               cli.rsp_valid_o, cli.rsp_data_o, err_o);
    end
  endtask

  task automatic test_tag_full();
    do_reset();
    cli.req_valid_i[0] = 1'b1;
    cli.req_addr_i[0]  = 24'h000400;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cli.req_ready_o !== 4'b0001) begin
        errors++;
        $display("FAIL tf_fill%0d: got %b expected 0001",
                 i, cli.req_ready_o);
      end
      tick();
      tick();
    end
    checks++;
    if (outstanding_o !== 4'd8 || cli.req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL tf_full: got %0d/%b expected 8/0000",
               outstanding_o, cli.req_ready_o);
    end
    cli.req_valid_i[3] = 1'b1;
    cli.req_we_i[3]    = 1'b1;
    cli.req_addr_i[3]  = 24'h000333;
    cli.req_data_i[3]  = 16'h5A5A;
    #1;
    checks++;
    if (cli.req_ready_o !== 4'b1000) begin
      errors++;
      $display("FAIL tf_write_grant: got %b expected 1000",
               cli.req_ready_o);
    end
    tick();
    cli.req_valid_i[3] = 1'b0;
    checks++;
    if (writer_enq_o !== 1'b1 ||
        writer_d_o !== {1'b1, 24'h000333, 16'h5A5A}) begin
      errors++;
      $display("FAIL tf_write_cmd: got %b/%h expected 1/%h",
               writer_enq_o, writer_d_o,
               {1'b1, 24'h000333, 16'h5A5A});
    end
    tick();
    checks++;
    if (cli.req_ready_o !== 4'b0000) begin
      errors++;
      $display("FAIL tf_blocked: got %b expected 0000",
               cli.req_ready_o);
    end
    send_rsp(16'h7777);
    checks++;
    if (cli.rsp_valid_o !== 4'b0001 || outstanding_o !== 4'd7 ||
        cli.req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL tf_reopen: got %b/%0d/%b expected 0001/7/0001",
               cli.rsp_valid_o, outstanding_o, cli.req_ready_o);
    end
    tick();
    cli.req_valid_i[0] = 1'b0;
    checks++;
    if (outstanding_o !== 4'd8) begin
      errors++;
      $display("FAIL tf_refill: got %0d expected 8",
               outstanding_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cli.req_valid_i[0] = 1'b1;
    cli.req_we_i       = 4'b1111;
    cli.req_addr_i[0]  = 24'h000010;
    cli.req_data_i[0]  = 16'h0101;
    #1;
    checks++;
    if (cli.req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL bp_first: got %b expected 0001",
               cli.req_ready_o);
    end
    tick();
    writer_full_i     = 1'b1;
    cli.req_valid_i   = 4'b1101;
    cli.req_addr_i[2] = 24'h000020;
    cli.req_data_i[2] = 16'h0202;
    cli.req_addr_i[3] = 24'h000030;
    cli.req_data_i[3] = 16'h0303;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (cli.req_ready_o !== 4'b0000 || writer_enq_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got %b/%b expected 0000/0",
                 i, cli.req_ready_o, writer_enq_o);
      end
    end
    writer_full_i = 1'b0;
    #1;
    checks++;
    if (cli.req_ready_o !== 4'b0100) begin
      errors++;
      $display("FAIL bp_resume: got %b expected 0100",
               cli.req_ready_o);
    end
    tick();
    cli.req_valid_i[2] = 1'b0;
    checks++;
    if (writer_enq_o !== 1'b1 ||
        writer_d_o !== {1'b1, 24'h000020, 16'h0202}) begin
      errors++;
      $display("FAIL bp_cmd: got %b/%h expected 1/%h",
               writer_enq_o, writer_d_o,
               {1'b1, 24'h000020, 16'h0202});
    end
    tick();
    checks++;
    if (cli.req_ready_o !== 4'b1000) begin
      errors++;
      $display("FAIL bp_next: got %b expected 1000",
               cli.req_ready_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_spurious_reset();
    do_reset();
    reader_q_i     = 16'hDEAD;
    reader_empty_i = 1'b0;
    tick();
    reader_empty_i = 1'b1;
    checks++;
    if (reader_deq_o !== 1'b1) begin
      errors++;
      $display("FAIL sp_deq: got %b expected 1", reader_deq_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b1 || cli.rsp_valid_o !== 4'b0000 ||
        cli.rsp_data_o !== 16'h0000) begin
      errors++;
      $display("FAIL sp_err: got %b/%b/%h expected 1/0000/0000",
               err_o, cli.rsp_valid_o, cli.rsp_data_o);
    end
    repeat (3) tick();
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL sp_sticky: got %b expected 1", err_o);
    end
    cli.req_valid_i = 4'b1111;
    reader_q_i      = 16'h1234;
    reader_empty_i  = 1'b0;
    tick();
    checks++;
    if (writer_enq_o !== 1'b1 || outstanding_o !== 4'd1 ||
        reader_deq_o !== 1'b1) begin
      errors++;
      $display("FAIL mr_busy: got %b/%0d/%b expected 1/1/1",
               writer_enq_o, outstanding_o, reader_deq_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if ({err_o, writer_enq_o, reader_deq_o} !== 3'b000 ||
        outstanding_o !== 4'd0 || cli.rsp_valid_o !== 4'b0000 ||
        writer_d_o !== 41'h0) begin
      errors++;
      $display("FAIL mr_clear: got %b/%0d/%b/%h expected 000/0/0000/0",
               {err_o, writer_enq_o, reader_deq_o},
               outstanding_o, cli.rsp_valid_o, writer_d_o);
    end
    idle_inputs();
    tick();
    reset_i = 1'b0;
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL mr_err_after: got %b expected 0", err_o);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_routing();
    test_tag_full();
    test_backpressure();
    test_spurious_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Round-robin arbiter that lets NUM_REQ client ports share the command (writer) and response (reader) queues of `async_sdram_ctrl`. It sits in the `clk` domain between the clients and the controller's FIFO ports. Commands from the clients are serialised into the 41-bit writer format. Read data, which the controller returns in issue order, is routed back to the client that issued the read, using an internal tag FIFO.

## Interface
Parameters:
- NUM_REQ, 4: number of client ports (2..8).
- TAG_DEPTH, 8: maximum number of outstanding reads (power of two).

Ports:
- clk  in  1  system clock; sole clock of the block.
- reset_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-client command request.
- req_we_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  NUM_REQ×24  word address per client.
- req_data_i  in  NUM_REQ×16  write data per client; ignored for reads.
- req_ready_o  out  NUM_REQ  one-hot accept strobe, combinational.
- rsp_valid_o  out  NUM_REQ  one-hot, one-cycle read-data strobe.
- rsp_data_o  out  16  read data, shared by all clients.
- writer_d_o  out  41  {we, addr[23:0], data[15:0]} to the controller.
- writer_enq_o  out  1  enqueue strobe.
- writer_full_i  in  1  controller command FIFO full.
- reader_q_i  in  16  controller read data.
- reader_deq_o  out  1  dequeue strobe.
- reader_empty_i  in  1  controller response FIFO empty.
- outstanding_o  out  $clog2(TAG_DEPTH)+1  number of reads issued but not yet returned.
- err_o  out  1  sticky error: response received with no outstanding tag.

## Operation
Reset values:
- writer_enq_o, reader_deq_o, rsp_valid_o, err_o: 0.
- writer_d_o, rsp_data_o: 0.
- outstanding_o: 0.
- Round-robin pointer: 0.
- Tag FIFO: empty.
- Response FSM: R_IDLE.

Command path:
- Issue window is open when all of the following hold:
  - writer_full_i = 0;
  - writer_enq_o was 0 in the previous cycle (one-cycle gap covers the full-flag update latency);
  - at least one eligible request exists.
- Eligibility: client i is eligible when req_valid_i[i] = 1 and either req_we_i[i] = 1 or the tag FIFO is not full.
- Grant: the first eligible client found by searching upward from the pointer, wrapping modulo NUM_REQ.
- req_ready_o[grant] = 1 in that cycle. A transfer occurs when valid and ready are both high.
- At the next edge:
  - writer_d_o ← {we, addr, data}, with data forced to 0 for reads;
  - writer_enq_o ← 1 for exactly one cycle;
  - pointer ← grant + 1 (mod NUM_REQ);
  - for a read, grant index is pushed into the tag FIFO.
- A client must hold valid and its payload stable until it sees ready.
- When the tag FIFO is full, reads are blocked. Writes from other clients may still be granted.

Response FSM:
- R_IDLE:
  - If reader_empty_i = 0: reader_deq_o ← 1 for one cycle → R_CAP.
- R_CAP (reader_q_i is valid in this cycle, one-cycle read latency):
  - If the tag FIFO is non-empty: rsp_data_o ← reader_q_i, rsp_valid_o[tag head] ← 1 for one cycle, pop tag.
  - If the tag FIFO is empty: discard the word, err_o ← 1.
  - → R_IDLE.
- Throughput: one response every 2 cycles. Responses are delivered in issue order.

Simultaneous events and counting:
- A tag push and pop in the same cycle are both performed; outstanding_o is unchanged.
- outstanding_o equals the tag FIFO level.

Reset mid-operation:
- All state clears immediately. Outstanding tags are lost.
- Late controller responses then take the err_o path. The system must reset the controller alongside this block.

## Timing
- Command latency: req accepted in cycle N → writer_enq_o high in cycle N+1.
- Minimum spacing of 2 cycles between enqueues. Peak command rate is one command per 2 cycles.
- Response latency: reader_empty_i low at cycle M (FSM in R_IDLE) → reader_deq_o high at M+1 → rsp_valid_o high at M+2.
- rsp_data_o holds its value until the next response.
- All outputs are registered except req_ready_o.

## Structure
- Package `sdram_arb_pkg`:
  - CMD_W = 41, ADDR_W = 24, DATA_W = 16;
  - cmd_t packed struct {we, addr, data};
  - rsp_state_t enum {R_IDLE, R_CAP}.
- Sub-module `sdram_tag_fifo`:
  - synchronous FIFO, width $clog2(NUM_REQ), depth TAG_DEPTH;
  - push, pop, head, full, empty, level;
  - handles simultaneous push and pop.
- Top level holds the round-robin arbiter, the command register and the response FSM.

## Test plan
- Single write: client 1 writes addr 0x000010, data 0xBEEF → writer_d_o = {1, 0x000010, 0xBEEF}, with a one-cycle writer_enq_o one cycle after ready.
- Round-robin: all 4 clients hold valid (reads) → grants 0, 1, 2, 3, 0, with enqueues spaced exactly 2 cycles apart.
- Read routing: clients 2 and 0 read in that order; model returns 0x1111 then 0x2222 → rsp_valid_o[2] with 0x1111, then rsp_valid_o[0] with 0x2222.
- Tag full: TAG_DEPTH = 8 reads with no responses → outstanding_o = 8, further reads not granted, a write from another client is still granted; one response → a read is granted again.
- Backpressure: writer_full_i held high for 10 cycles → no req_ready_o and no writer_enq_o; on release, the grant resumes from the saved pointer.
- Spurious response and reset: reader_empty_i low with no tags → word dequeued, err_o = 1 and sticky. Asserting reset_i mid-burst clears err_o, outstanding_o and all strobes immediately.
